// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR lane demultiplexer.
package fir_pkg;

    localparam int DATA_W = 12;
    localparam int LANES  = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/fir_lane_reg.sv
// One lane register: holds a sample plus a flag marking that it was written this bundle.
import fir_pkg::*;

module fir_lane_reg #(
    parameter int DATA_W = fir_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o,
    output logic              vld_o
);

    logic [DATA_W-1:0] data_q;
    logic              vld_q;

    // Load wins over clear so a handoff cycle can clear the bundle and start lane 0 together.
    always_ff @(posedge clk) begin
        if (ld_i) begin
            data_q <= d_i;
            vld_q  <= 1'b1;
        end else if (clr_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/fir_lane_demux.sv
// Serial-to-parallel lane demux: fills LANES lane registers round-robin and hands the
// bundle to the tap bank with a valid/ready handshake.
import fir_pkg::*;

module fir_lane_demux #(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int LANES  = fir_pkg::LANES,
    parameter int SEL_W  = fir_pkg::SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        lane_idx
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lane_idx_q, lane_idx_d;
    logic [LANES-1:0]   ld_vec;
    logic               clr_all;
    logic               accept;
    logic               xfer;
    logic [DATA_W-1:0]  lane_q [LANES];
    logic [LANES-1:0]   lane_vld;

    assign out_valid = (state_q == ST_FULL);
    // A full bundle frees the lanes the same cycle it is taken, so input passes straight through.
    assign in_ready  = (state_q == ST_FILL) | out_ready;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        ld_vec     = '0;
        clr_all    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    ld_vec     = LANES'(1) << lane_idx_q;
                    lane_idx_d = lane_idx_q + 1'b1;
                    if (lane_idx_q == SEL_W'(LANES - 1) || in_last) begin
                        state_d    = ST_FULL;
                        lane_idx_d = '0;
                    end
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    clr_all    = 1'b1;
                    state_d    = ST_FILL;
                    lane_idx_d = '0;
                    if (accept) begin
                        ld_vec     = LANES'(1);
                        lane_idx_d = SEL_W'(1);
                        if (in_last) begin
                            state_d    = ST_FULL;
                            lane_idx_d = '0;
                        end
                    end
                end
            end
            default: begin
                clr_all    = 1'b1;
                state_d    = ST_FILL;
                lane_idx_d = '0;
            end
        endcase
        if (!rst_n) begin
            clr_all = 1'b1;
            ld_vec  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            lane_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fir_lane_reg #(.DATA_W(DATA_W)) u_lane (
            .clk   (clk),
            .clr_i (clr_all),
            .ld_i  (ld_vec[k]),
            .d_i   (in_data),
            .q_o   (lane_q[k]),
            .vld_o (lane_vld[k])
        );
        assign out_data[k*DATA_W +: DATA_W] = lane_q[k];
    end

    assign out_lane_valid = lane_vld;
    assign lane_idx       = lane_idx_q;

endmodule

// File: tb/tb_fir_lane_demux.sv
// Directed bench for fir_lane_demux: reset, fill, flush, streaming, backpressure, mid-bundle reset.
module tb_fir_lane_demux;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [47:0] out_data;
    logic [3:0]  out_lane_valid;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  lane_idx;

    int n_cmp;
    int n_fail;

    fir_lane_demux dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .lane_idx       (lane_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [11:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        cyc(); cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (lane_idx !== 2'd0) begin n_fail++; $display("FAIL reset_lane_idx got %0d want 0", lane_idx); end
        n_cmp++; if (out_lane_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_lane_valid got %b want 0000", out_lane_valid); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_full_bundle();
        out_ready = 1'b0;
        feed(12'h001, 1'b0);
        n_cmp++; if (lane_idx !== 2'd1) begin n_fail++; $display("FAIL full_lane_idx1 got %0d want 1", lane_idx); end
        feed(12'h002, 1'b0);
        feed(12'h003, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %b want 0", out_valid); end
        feed(12'h004, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 48'h004003002001) begin n_fail++; $display("FAIL full_out_data got %h want 004003002001", out_data); end
        n_cmp++; if (out_lane_valid !== 4'b1111) begin n_fail++; $display("FAIL full_lane_valid got %b want 1111", out_lane_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (lane_idx !== 2'd0) begin n_fail++; $display("FAIL full_lane_idx got %0d want 0", lane_idx); end
        drain();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL drain_out_data got %h want 0", out_data); end
    endtask

    task automatic test_early_flush();
        feed(12'hABC, 1'b0);
        feed(12'h123, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_out_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 48'h000000123ABC) begin n_fail++; $display("FAIL flush_out_data got %h want 000000123abc", out_data); end
        n_cmp++; if (out_lane_valid !== 4'b0011) begin n_fail++; $display("FAIL flush_lane_valid got %b want 0011", out_lane_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 12'h010 + 12'(i);
            in_last  = 1'b0;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready word %0d got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            if (i == 3) begin
                n_cmp++; if (out_data !== 48'h013012011010) begin n_fail++; $display("FAIL b2b_bundle1 got %h want 013012011010", out_data); end
            end
            if (i == 4) begin
                n_cmp++; if (lane_idx !== 2'd1) begin n_fail++; $display("FAIL b2b_lane_idx got %0d want 1", lane_idx); end
                n_cmp++; if (out_lane_valid !== 4'b0001) begin n_fail++; $display("FAIL b2b_lane_valid got %b want 0001", out_lane_valid); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid2 got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 48'h017016015014) begin n_fail++; $display("FAIL b2b_bundle2 got %h want 017016015014", out_data); end
        cyc();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        feed(12'h101, 1'b0);
        feed(12'h102, 1'b0);
        feed(12'h103, 1'b0);
        feed(12'h104, 1'b0);
        in_valid = 1'b1;
        in_data  = 12'h555;
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_cmp++; if (out_data !== 48'h104103102101) begin n_fail++; $display("FAIL bp_hold_data cycle %0d got %h want 104103102101", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
        in_data   = 12'h7FF;
        out_ready = 1'b1;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_xfer_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 48'h0000000007FF) begin n_fail++; $display("FAIL bp_lane0 got %h want 0000000007ff", out_data); end
        n_cmp++; if (out_lane_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_lane_valid got %b want 0001", out_lane_valid); end
        n_cmp++; if (lane_idx !== 2'd1) begin n_fail++; $display("FAIL bp_lane_idx got %0d want 1", lane_idx); end
        feed(12'h001, 1'b0);
        feed(12'h002, 1'b0);
        feed(12'h003, 1'b0);
        n_cmp++; if (out_data !== 48'h0030020017FF) begin n_fail++; $display("FAIL bp_next_bundle got %h want 0030020017ff", out_data); end
        drain();
    endtask

    task automatic test_mid_reset();
        feed(12'hAAA, 1'b0);
        feed(12'hBBB, 1'b0);
        rst_n = 1'b0;
        cyc();
        n_cmp++; if (lane_idx !== 2'd0) begin n_fail++; $display("FAIL mrst_lane_idx got %0d want 0", lane_idx); end
        n_cmp++; if (out_lane_valid !== 4'b0000) begin n_fail++; $display("FAIL mrst_lane_valid got %b want 0000", out_lane_valid); end
        rst_n = 1'b1;
        feed(12'h021, 1'b0);
        feed(12'h022, 1'b0);
        feed(12'h023, 1'b0);
        feed(12'h024, 1'b0);
        n_cmp++; if (out_data !== 48'h024023022021) begin n_fail++; $display("FAIL mrst_bundle got %h want 024023022021", out_data); end
        n_cmp++; if (out_lane_valid !== 4'b1111) begin n_fail++; $display("FAIL mrst_bundle_valid got %b want 1111", out_lane_valid); end
        drain();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_full_bundle();
        test_early_flush();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
